arp_ctrl: RTL and testbench

ARP control engine that sits between the user logic and the `arp` block (ARP transmitter, receiver and CRC) on the shared GMII clock. It answers every received ARP request with an ARP reply. On demand, it resolves a target IP to a MAC address by broadcasting ARP requests, with timeout and bounded retry. The resolved MAC is held in a single-entry cache for the UDP path.

---
 rtl/arp_ctrl.sv | 155 +++++++++++++++
 tb/tb_arp_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_ctrl.sv
// ARP control engine: answers ARP requests with replies and resolves a target IP
// to a MAC with timeout/retry, keeping the result in a single-entry cache.
module arp_ctrl #(
    parameter logic [31:0] BOARD_IP     = 32'hC0_A8_00_02,
    parameter int          RETRY_CYCLES = 125_000_000,
    parameter int          MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        gmii_tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    output logic        busy,
    output logic        resolved_valid,
    output logic [31:0] resolved_ip,
    output logic [47:0] resolved_mac,
    output logic        resolve_fail
);

    localparam logic [31:0] TIMER_LAST = 32'(RETRY_CYCLES - 1);
    localparam logic [3:0]  RETRY_LAST = 4'(MAX_RETRY - 1);

    typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT} rstate_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tstate_t;

    rstate_t     rstate;
    tstate_t     tstate;
    logic [31:0] target;
    logic [47:0] reply_mac;
    logic [31:0] reply_ip;
    logic        reply_pending;
    logic        req_pending;
    logic [31:0] timer;
    logic [3:0]  retry;

    logic match;
    logic expire;
    logic req_sent;

    assign match    = arp_rx_done && arp_rx_type && busy && (src_ip == target);
    assign expire   = (rstate == R_WAIT) && (timer == TIMER_LAST);
    // Only the end of our own request frame starts the timeout, not a reply frame.
    assign req_sent = (tstate == T_WAIT) && gmii_tx_done && !arp_tx_type;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate         <= R_IDLE;
            tstate         <= T_IDLE;
            target         <= '0;
            reply_mac      <= '0;
            reply_ip       <= '0;
            reply_pending  <= 1'b0;
            req_pending    <= 1'b0;
            timer          <= '0;
            retry          <= '0;
            arp_tx_en      <= 1'b0;
            arp_tx_type    <= 1'b0;
            des_mac        <= '0;
            des_ip         <= '0;
            busy           <= 1'b0;
            resolved_valid <= 1'b0;
            resolved_ip    <= '0;
            resolved_mac   <= '0;
            resolve_fail   <= 1'b0;
        end else begin
            arp_tx_en    <= 1'b0;
            resolve_fail <= 1'b0;

            // Transmit scheduler: replies go out before requests.
            case (tstate)
                T_IDLE: begin
                    if (reply_pending) begin
                        arp_tx_en     <= 1'b1;
                        arp_tx_type   <= 1'b1;
                        des_mac       <= reply_mac;
                        des_ip        <= reply_ip;
                        reply_pending <= 1'b0;
                        tstate        <= T_START;
                    end else if (req_pending) begin
                        arp_tx_en   <= 1'b1;
                        arp_tx_type <= 1'b0;
                        des_mac     <= 48'hFF_FF_FF_FF_FF_FF;
                        des_ip      <= target;
                        req_pending <= 1'b0;
                        tstate      <= T_START;
                    end
                end
                T_START: tstate <= T_WAIT;
                T_WAIT:  if (gmii_tx_done) tstate <= T_IDLE;
                default: tstate <= T_IDLE;
            endcase

            // A newer request overwrites an unsent pending reply.
            if (arp_rx_done && !arp_rx_type) begin
                reply_mac     <= src_mac;
                reply_ip      <= src_ip;
                reply_pending <= 1'b1;
            end

            if (timer != 32'hFFFF_FFFF) timer <= timer + 32'd1;

            case (rstate)
                R_IDLE: begin
                    if (resolve_req) begin
                        if (resolve_ip == BOARD_IP) begin
                            resolve_fail <= 1'b1;
                        end else begin
                            target         <= resolve_ip;
                            resolved_valid <= 1'b0;
                            retry          <= '0;
                            busy           <= 1'b1;
                            req_pending    <= 1'b1;
                            rstate         <= R_SEND;
                        end
                    end
                end
                R_SEND, R_WAIT: begin
                    if (match) begin
                        resolved_mac   <= src_mac;
                        resolved_ip    <= target;
                        resolved_valid <= 1'b1;
                        busy           <= 1'b0;
                        req_pending    <= 1'b0;
                        rstate         <= R_IDLE;
                    end else if (rstate == R_SEND) begin
                        if (req_sent) begin
                            timer  <= '0;
                            rstate <= R_WAIT;
                        end
                    end else if (expire) begin
                        retry <= retry + 4'd1;
                        if (retry == RETRY_LAST) begin
                            resolve_fail <= 1'b1;
                            busy         <= 1'b0;
                            rstate       <= R_IDLE;
                        end else begin
                            req_pending <= 1'b1;
                            rstate      <= R_SEND;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_ctrl.sv
// Scoreboard bench for arp_ctrl: expected frames are queued when stimulus is
// driven and compared by a monitor when arp_tx_en fires.
module tb_arp_ctrl;

    localparam int          RETRY = 16;
    localparam int          MAXR  = 3;
    localparam int          FRAME = 20;
    localparam logic [31:0] BIP   = 32'hC0A80002;

    logic        clk, rst;
    logic        arp_rx_done, arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        gmii_tx_done;
    logic        arp_tx_en, arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        resolve_req;
    logic [31:0] resolve_ip;
    logic        busy, resolved_valid, resolve_fail;
    logic [31:0] resolved_ip;
    logic [47:0] resolved_mac;

    arp_ctrl #(.BOARD_IP(BIP), .RETRY_CYCLES(RETRY), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst),
        .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
        .src_mac(src_mac), .src_ip(src_ip),
        .gmii_tx_done(gmii_tx_done),
        .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
        .des_mac(des_mac), .des_ip(des_ip),
        .resolve_req(resolve_req), .resolve_ip(resolve_ip),
        .busy(busy), .resolved_valid(resolved_valid),
        .resolved_ip(resolved_ip), .resolved_mac(resolved_mac),
        .resolve_fail(resolve_fail)
    );

    // cyc >= 0: absolute cycle; -1: retry after timeout; -2: right after previous frame
    typedef struct {
        logic        t;
        logic [47:0] mac;
        logic [31:0] ip;
        int          cyc;
    } frame_t;

    frame_t      sb[$];
    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          last_done = 0, last_fail_cyc = 0;
    int          tx_count = 0, req_count = 0, fail_count = 0;
    bit          in_frame = 0, prev_en = 0;
    logic        cur_t;
    logic [47:0] cur_mac;
    logic [31:0] cur_ip;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    // Frame responder: gmii_tx_done ends every frame FRAME cycles after it starts.
    initial begin
        gmii_tx_done = 0;
        forever begin
            @(negedge clk);
            if (!rst && arp_tx_en) begin
                repeat (FRAME) @(posedge clk);
                #1 gmii_tx_done = 1;
                @(posedge clk);
                #1 gmii_tx_done = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        frame_t e;
        int     want;
        @(negedge clk);
        if (rst) begin
            in_frame = 0;
            prev_en  = 0;
        end else begin
            if (arp_tx_en) begin
                checks++;
                if (prev_en || in_frame) begin
                    failures++;
                    $display("FAIL tx_overlap: arp_tx_en at cycle %0d prev_en=%0b in_frame=%0b, required a gap after gmii_tx_done",
                             cyc, prev_en, in_frame);
                end
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected: frame type=%0b mac=%h ip=%h at cycle %0d, required none",
                             arp_tx_type, des_mac, des_ip, cyc);
                end else begin
                    e = sb.pop_front();
                    want = (e.cyc >= 0) ? e.cyc : (e.cyc == -1) ? last_done + RETRY + 2 : last_done + 2;
                    if (arp_tx_type !== e.t || des_mac !== e.mac || des_ip !== e.ip || cyc != want) begin
                        failures++;
                        $display("FAIL tx_frame: got type=%0b mac=%h ip=%h cyc=%0d, required type=%0b mac=%h ip=%h cyc=%0d",
                                 arp_tx_type, des_mac, des_ip, cyc, e.t, e.mac, e.ip, want);
                    end
                end
                cur_t = arp_tx_type; cur_mac = des_mac; cur_ip = des_ip;
                in_frame = 1;
                tx_count++;
                if (arp_tx_type == 1'b0) req_count++;
            end else if (in_frame) begin
                checks++;
                if (arp_tx_type !== cur_t || des_mac !== cur_mac || des_ip !== cur_ip) begin
                    failures++;
                    $display("FAIL tx_hold: got type=%0b mac=%h ip=%h, required type=%0b mac=%h ip=%h",
                             arp_tx_type, des_mac, des_ip, cur_t, cur_mac, cur_ip);
                end
                if (gmii_tx_done) begin
                    in_frame  = 0;
                    last_done = cyc;
                end
            end
            prev_en = arp_tx_en;
            if (resolve_fail) begin
                fail_count++;
                last_fail_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_pulse(input logic t, input logic [47:0] mac, input logic [31:0] ip);
        arp_rx_done = 1; arp_rx_type = t; src_mac = mac; src_ip = ip;
        tick();
        arp_rx_done = 0;
    endtask

    task automatic resolve_pulse(input logic [31:0] ip);
        resolve_req = 1; resolve_ip = ip;
        tick();
        resolve_req = 0;
    endtask

    task automatic wait_frames(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (sb.size() == 0 && !in_frame) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [164:0] all_out();
        return {arp_tx_en, arp_tx_type, des_mac, des_ip, busy, resolved_valid,
                resolved_ip, resolved_mac, resolve_fail};
    endfunction

    task automatic test_reset();
        rst = 1;
        arp_rx_done = 0; arp_rx_type = 0; src_mac = '0; src_ip = '0;
        resolve_req = 0; resolve_ip = '0;
        repeat (3) tick();
        checks++;
        if (all_out() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0", all_out());
        end
        rst = 0;
        repeat (2) tick();
    endtask

    task automatic test_reply();
        bit ok;
        sb.push_back('{1'b1, 48'hA82BDD25DA43, 32'hC0A80003, cyc + 2});
        rx_pulse(1'b0, 48'hA82BDD25DA43, 32'hC0A80003);
        wait_frames(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reply_done: reply frame did not complete, queue=%0d", sb.size());
        end
        repeat (4) tick();
    endtask

    task automatic test_resolve_success();
        bit ok;
        int fc;
        fc = fail_count;
        sb.push_back('{1'b0, 48'hFFFFFFFFFFFF, 32'hC0A80003, cyc + 2});
        resolve_pulse(32'hC0A80003);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL resolve_busy: got %0b, required 1", busy);
        end
        wait_frames(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL resolve_req_frame: request frame did not complete");
        end
        rx_pulse(1'b1, 48'hDEADBEEF0001, 32'hC0A80009);
        checks++;
        if (resolved_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL resolve_other_ip: got valid=%0b busy=%0b, required valid=0 busy=1", resolved_valid, busy);
        end
        rx_pulse(1'b1, 48'h112233445566, 32'hC0A80003);
        checks++;
        if (resolved_valid !== 1'b1 || busy !== 1'b0 || resolved_mac !== 48'h112233445566 ||
            resolved_ip !== 32'hC0A80003) begin
            failures++;
            $display("FAIL resolve_hit: got valid=%0b busy=%0b mac=%h ip=%h, required 1 0 112233445566 c0a80003",
                     resolved_valid, busy, resolved_mac, resolved_ip);
        end
        repeat (40) tick();
        checks++;
        if (fail_count != fc || sb.size() != 0) begin
            failures++;
            $display("FAIL resolve_quiet: got fail pulses=%0d, required 0", fail_count - fc);
        end
    endtask

    task automatic test_timeout();
        int rc, fc;
        bit seen;
        rc = req_count;
        fc = fail_count;
        seen = 0;
        sb.push_back('{1'b0, 48'hFFFFFFFFFFFF, 32'hC0A80077, cyc + 2});
        sb.push_back('{1'b0, 48'hFFFFFFFFFFFF, 32'hC0A80077, -1});
        sb.push_back('{1'b0, 48'hFFFFFFFFFFFF, 32'hC0A80077, -1});
        resolve_pulse(32'hC0A80077);
        for (int i = 0; i < 400; i++) begin
            if (fail_count != fc) begin
                seen = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_fail_seen: no resolve_fail within bound, required one");
        end
        checks++;
        if (last_fail_cyc != last_done + RETRY + 1) begin
            failures++;
            $display("FAIL timeout_fail_cycle: got %0d, required %0d", last_fail_cyc, last_done + RETRY + 1);
        end
        checks++;
        if (req_count - rc != MAXR || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_requests: got %0d requests busy=%0b, required %0d busy=0",
                     req_count - rc, busy, MAXR);
        end
        repeat (40) tick();
        checks++;
        if (fail_count != fc + 1 || sb.size() != 0 || req_count - rc != MAXR || resolved_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_after: got fail cycles=%0d requests=%0d valid=%0b, required 1 %0d 0",
                     fail_count - fc, req_count - rc, resolved_valid, MAXR);
        end
    endtask

    task automatic test_priority();
        bit ok;
        sb.push_back('{1'b1, 48'h0A0B0C0D0E0F, 32'hC0A80044, cyc + 2});
        sb.push_back('{1'b0, 48'hFFFFFFFFFFFF, 32'hC0A80005, -2});
        arp_rx_done = 1; arp_rx_type = 0; src_mac = 48'h0A0B0C0D0E0F; src_ip = 32'hC0A80044;
        resolve_req = 1; resolve_ip = 32'hC0A80005;
        tick();
        arp_rx_done = 0; resolve_req = 0;
        wait_frames(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL priority_frames: frames did not complete, queue=%0d", sb.size());
        end
        rx_pulse(1'b1, 48'h665544332211, 32'hC0A80005);
        checks++;
        if (resolved_valid !== 1'b1 || resolved_ip !== 32'hC0A80005 || resolved_mac !== 48'h665544332211) begin
            failures++;
            $display("FAIL priority_resolve: got valid=%0b ip=%h mac=%h, required 1 c0a80005 665544332211",
                     resolved_valid, resolved_ip, resolved_mac);
        end
        repeat (4) tick();
    endtask

    task automatic test_boundaries();
        bit ok;
        resolve_pulse(BIP);
        checks++;
        if (resolve_fail !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL board_ip_fail: got fail=%0b busy=%0b, required fail=1 busy=0", resolve_fail, busy);
        end
        tick();
        checks++;
        if (resolve_fail !== 1'b0) begin
            failures++;
            $display("FAIL board_ip_pulse: got fail=%0b a cycle later, required 0", resolve_fail);
        end
        sb.push_back('{1'b0, 48'hFFFFFFFFFFFF, 32'hC0A80010, cyc + 2});
        resolve_pulse(32'hC0A80010);
        resolve_pulse(32'hC0A80011);
        wait_frames(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL busy_ignore_frame: request frame did not complete");
        end
        rx_pulse(1'b1, 48'h000000000011, 32'hC0A80011);
        checks++;
        if (resolved_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore_target: got valid=%0b busy=%0b, required valid=0 busy=1", resolved_valid, busy);
        end
        rx_pulse(1'b1, 48'h000000000010, 32'hC0A80010);
        checks++;
        if (resolved_valid !== 1'b1 || resolved_ip !== 32'hC0A80010 || resolved_mac !== 48'h000000000010) begin
            failures++;
            $display("FAIL busy_ignore_hit: got valid=%0b ip=%h mac=%h, required 1 c0a80010 000000000010",
                     resolved_valid, resolved_ip, resolved_mac);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_frame();
        int tc;
        sb.push_back('{1'b1, 48'h1234567890AB, 32'hC0A80066, cyc + 2});
        rx_pulse(1'b0, 48'h1234567890AB, 32'hC0A80066);
        repeat (5) tick();
        rst = 1;
        #1;
        checks++;
        if (all_out() !== '0) begin
            failures++;
            $display("FAIL reset_mid_frame: got %h, required 0", all_out());
        end
        repeat (2) tick();
        rst = 0;
        tc = tx_count;
        repeat (FRAME + 15) tick();
        checks++;
        if (all_out() !== '0 || tx_count != tc) begin
            failures++;
            $display("FAIL reset_late_done: got outputs=%h new frames=%0d, required 0 and 0", all_out(), tx_count - tc);
        end
    endtask

    initial begin
        test_reset();
        test_reply();
        test_resolve_success();
        test_timeout();
        test_priority();
        test_boundaries();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
